// File: rtl/c3lib_strap_pkg.sv
// Shared types for the strap capture/override controller.
// State encoding is fixed at 2 bits so the state register is a plain 2-flop vector.
package c3lib_strap_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    CAP_A  = 2'd1,
    CAP_B  = 2'd2,
    READY  = 2'd3
  } strap_state_t;

endpackage

// File: rtl/c3lib_strap_cfg_ctrl.sv
// Settle, double-sample and publish tie-cell straps; firmware override until sticky lock.
// First cfg_valid SETTLE_CYCLES+2 edges after reset; no backpressure, cap_req/ovr_wr_en are single-cycle strobes.
module c3lib_strap_cfg_ctrl
  import c3lib_strap_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] strap_in,
  input  logic             cap_req,
  input  logic             ovr_wr_en,
  input  logic [WIDTH-1:0] ovr_wr_data,
  input  logic             ovr_lock,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_valid,
  output logic             cfg_src,
  output logic             busy,
  output logic             mismatch,
  output logic             locked
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  strap_state_t     state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shadow;

  assign busy = (state != READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SETTLE;
      cnt       <= '0;
      shadow    <= '0;
      cfg_out   <= '0;
      cfg_valid <= 1'b0;
      cfg_src   <= 1'b0;
      mismatch  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            state <= CAP_A;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAP_A: begin
          shadow <= strap_in;
          state  <= CAP_B;
        end
        CAP_B: begin
          // Two samples one cycle apart must agree, otherwise wait a full settle window again.
          if (strap_in == shadow) begin
            cfg_out   <= strap_in;
            cfg_valid <= 1'b1;
            cfg_src   <= 1'b0;
            mismatch  <= 1'b0;
            state     <= READY;
          end else begin
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        READY: begin
          if (!cfg_src && (strap_in != cfg_out))
            mismatch <= 1'b1;
          if (!locked) begin
            if (cap_req) begin
              cfg_valid <= 1'b0;
              cfg_src   <= 1'b0;
              state     <= SETTLE;
            end else if (ovr_wr_en) begin
              cfg_out  <= ovr_wr_data;
              cfg_src  <= 1'b1;
              mismatch <= 1'b0;
            end
          end
          if (ovr_lock && cfg_valid)
            locked <= 1'b1;
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c3lib_strap_cfg_ctrl.sv
// Randomized and directed bench for c3lib_strap_cfg_ctrl against a timeline-based reference model.
module tb_c3lib_strap_cfg_ctrl;

  localparam int W = 8;
  localparam int S = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] strap_in = 8'hA5;
  logic         cap_req = 1'b0;
  logic         ovr_wr_en = 1'b0;
  logic [W-1:0] ovr_wr_data = '0;
  logic         ovr_lock = 1'b0;
  logic [W-1:0] cfg_out;
  logic         cfg_valid, cfg_src, busy, mismatch, locked;

  int total = 0;
  int bad   = 0;

  c3lib_strap_cfg_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .strap_in(strap_in), .cap_req(cap_req),
    .ovr_wr_en(ovr_wr_en), .ovr_wr_data(ovr_wr_data), .ovr_lock(ovr_lock),
    .cfg_out(cfg_out), .cfg_valid(cfg_valid), .cfg_src(cfg_src),
    .busy(busy), .mismatch(mismatch), .locked(locked)
  );

  always #5 clk = ~clk;

  // Model: capture is a timeline position 0..S+1 (S = first sample, S+1 = compare).
  bit           m_ready;
  int           m_pos;
  logic [W-1:0] m_shadow, m_cfg;
  bit           m_valid, m_src, m_mis, m_lock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_pos = 0; m_shadow = '0; m_cfg = '0;
    m_valid = 0; m_src = 0; m_mis = 0; m_lock = 0;
  endtask

  task automatic model_step(input logic [W-1:0] s, input bit c, input bit w,
                            input logic [W-1:0] d, input bit l);
    if (!m_ready) begin
      if (m_pos == S + 1) begin
        if (s == m_shadow) begin
          m_ready = 1; m_cfg = s; m_valid = 1; m_src = 0; m_mis = 0;
        end else begin
          m_pos = 0;
        end
      end else begin
        if (m_pos == S) m_shadow = s;
        m_pos++;
      end
    end else begin
      bit was_locked;
      was_locked = m_lock;
      if (!m_src && s != m_cfg) m_mis = 1;
      if (l) m_lock = 1;
      if (!was_locked) begin
        if (c) begin
          m_valid = 0; m_src = 0; m_ready = 0; m_pos = 0;
        end else if (w) begin
          m_cfg = d; m_src = 1; m_mis = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cfg_out"},   32'(cfg_out),   32'(m_cfg));
    chk({tag, ".cfg_valid"}, 32'(cfg_valid), 32'(m_valid));
    chk({tag, ".cfg_src"},   32'(cfg_src),   32'(m_src));
    chk({tag, ".busy"},      32'(busy),      32'(!m_ready));
    chk({tag, ".mismatch"},  32'(mismatch),  32'(m_mis));
    chk({tag, ".locked"},    32'(locked),    32'(m_lock));
  endtask

  // Called #1 after a rising edge; drives inputs, steps across the next edge, checks.
  task automatic cyc(input logic [W-1:0] s, input bit c, input bit w,
                     input logic [W-1:0] d, input bit l, input string tag);
    strap_in = s; cap_req = c; ovr_wr_en = w; ovr_wr_data = d; ovr_lock = l;
    @(posedge clk);
    model_step(s, c, w, d, l);
    #1;
    check_all(tag);
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any edge.
  task automatic do_areset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int n;
  bit saw_ff;
  logic [W-1:0] rs;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;

    // First capture after reset: valid rises on edge S+2.
    n = 0;
    do begin cyc(8'hA5, 0, 0, 8'h00, 0, "first"); n++; end
    while (!cfg_valid && n < 100);
    chk("first_valid_edge", 32'(n), 32'(S + 2));
    chk("first_cfg", 32'(cfg_out), 32'hA5);

    // Straps change between the two samples: one full retry.
    cyc(8'hA5, 1, 0, 8'h00, 0, "cap_req");
    chk("cap_drop_valid", 32'(cfg_valid), 32'd0);
    n = 0;
    do begin cyc((n < S + 1) ? 8'hA5 : 8'h5A, 0, 0, 8'h00, 0, "retry"); n++; end
    while (!cfg_valid && n < 200);
    chk("retry_edges", 32'(n), 32'(2 * (S + 2)));
    chk("retry_cfg", 32'(cfg_out), 32'h5A);

    // Override, then strap changes do not raise mismatch.
    cyc(8'h5A, 0, 1, 8'h3C, 0, "ovr");
    chk("ovr_cfg", 32'(cfg_out), 32'h3C);
    chk("ovr_src", 32'(cfg_src), 32'd1);
    repeat (3) cyc(8'h11, 0, 0, 8'h00, 0, "ovr_hold");
    chk("ovr_no_mis", 32'(mismatch), 32'd0);

    // Recapture A5, then divergence sets mismatch, recapture clears it.
    cyc(8'hA5, 1, 0, 8'h00, 0, "cap2");
    n = 0;
    do begin cyc(8'hA5, 0, 0, 8'h00, 0, "cap2w"); n++; end
    while (!cfg_valid && n < 100);
    cyc(8'hA4, 0, 0, 8'h00, 0, "diverge");
    chk("mis_set", 32'(mismatch), 32'd1);
    cyc(8'hA4, 1, 0, 8'h00, 0, "cap3");
    n = 0;
    do begin cyc(8'hA4, 0, 0, 8'h00, 0, "cap3w"); n++; end
    while (!cfg_valid && n < 100);
    chk("mis_clr", 32'(mismatch), 32'd0);
    chk("cap3_cfg", 32'(cfg_out), 32'hA4);

    // cap_req beats a same-cycle override write.
    saw_ff = 0;
    cyc(8'hA4, 1, 1, 8'hFF, 0, "cap_vs_wr");
    n = 0;
    do begin
      cyc(8'hA4, 0, 0, 8'h00, 0, "cvw");
      if (cfg_out == 8'hFF) saw_ff = 1;
      n++;
    end while (!cfg_valid && n < 100);
    chk("never_ff", 32'(saw_ff), 32'd0);

    // Lock freezes everything.
    cyc(8'hA4, 0, 0, 8'h00, 1, "lock");
    chk("locked", 32'(locked), 32'd1);
    cyc(8'hA4, 0, 1, 8'h77, 0, "lk_wr");
    cyc(8'hA4, 1, 0, 8'h00, 0, "lk_cap");
    chk("lk_cfg", 32'(cfg_out), 32'hA4);
    chk("lk_busy", 32'(busy), 32'd0);

    // Async reset in locked READY, then in CAP_B.
    do_areset("arst_locked");
    chk("arst_unlock", 32'(locked), 32'd0);
    repeat (S + 1) cyc(8'h3C, 0, 0, 8'h00, 0, "to_capb");
    do_areset("arst_capb");

    // Randomized traffic.
    rs = 8'h3C;
    for (int i = 0; i < 1500; i++) begin
      bit c, w, l;
      if ($urandom_range(7) == 0) rs = W'($urandom);
      c = ($urandom_range(19) == 0);
      w = ($urandom_range(9) == 0);
      l = ($urandom_range(399) == 0);
      if ($urandom_range(299) == 0) do_areset("arst_rand");
      else cyc(rs, c, w, W'($urandom), l, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c3lib_strap_cfg_ctrl.md
# c3lib_strap_cfg_ctrl

Capture-and-override controller for metal-programmable strap bits driven by tie-low/tie-high cells. After reset it waits a settle window, double-samples the strap vector, and publishes a validated configuration word. Firmware may override the word until a sticky lock is applied. Sits between the tie-cell strap bank and the consuming PHY/adapter configuration logic.

## Interface
- WIDTH, 8, strap/config vector width (1..32)
- SETTLE_CYCLES, 16, clk cycles waited before first sample (>=1)
- clk  input  1  block clock
- rst  input  1  asynchronous, active-high reset
- strap_in  input  WIDTH  quasi-static strap values from tie cells
- cap_req  input  1  single-cycle request to re-capture straps
- ovr_wr_en  input  1  single-cycle override write strobe
- ovr_wr_data  input  WIDTH  override value
- ovr_lock  input  1  level; sets sticky lock when sampled high with cfg_valid=1
- cfg_out  output  WIDTH  published configuration word
- cfg_valid  output  1  cfg_out valid
- cfg_src  output  1  0 = straps, 1 = override
- busy  output  1  capture sequence in progress
- mismatch  output  1  sticky: straps differ from published strap-sourced word
- locked  output  1  sticky lock status

## Operation
- States: SETTLE, CAP_A, CAP_B, READY.
- Reset: state=SETTLE, counter=0, cfg_out=0, cfg_valid=0, cfg_src=0, busy=1, mismatch=0, locked=0, shadow=0.
- SETTLE: counter increments each cycle; at counter==SETTLE_CYCLES-1 go CAP_A, clear counter. Counter width $clog2(SETTLE_CYCLES+1).
- CAP_A: shadow <= strap_in; go CAP_B.
- CAP_B: if strap_in==shadow: cfg_out<=strap_in, cfg_valid<=1, cfg_src<=0, mismatch<=0, go READY. Else go SETTLE (counter=0, full retry; no retry limit).
- busy = (state != READY), combinational from state register.
- READY, unlocked, priority order: cap_req -> cfg_valid<=0, cfg_src<=0, go SETTLE; else ovr_wr_en -> cfg_out<=ovr_wr_data, cfg_src<=1, mismatch<=0.
- READY: ovr_lock=1 -> locked<=1 (same cycle ovr_wr_en still applies, lock effective next cycle).
- Locked: cap_req and ovr_wr_en ignored; cfg_out frozen; only rst clears lock.
- ovr_wr_en, ovr_lock outside READY ignored; cap_req outside READY ignored (sequence already running).
- mismatch: in READY with cfg_src=0, strap_in!=cfg_out sets mismatch (sticky); cleared only by successful capture, override write, or reset. Never set when cfg_src=1.
- rst mid-sequence: immediate return to reset values regardless of state.

## Timing
- All outputs registered except busy (decode of state register).
- First cfg_valid: high after edge SETTLE_CYCLES+2, counting first edge after rst deassert as edge 1.
- Re-capture: cfg_valid low after edge carrying cap_req; high again SETTLE_CYCLES+2 edges later (no strap change).
- Override: cfg_out/cfg_src update on edge sampling ovr_wr_en.
- mismatch: asserts one edge after strap_in diverges.
- Each CAP_B mismatch adds SETTLE_CYCLES+2 cycles.

## Structure
- Package c3lib_strap_pkg: state enum (SETTLE, CAP_A, CAP_B, READY), 2-bit encoding.
- Single module; no sub-module. Strap inputs are static by construction, no synchroniser instantiated.

## Test plan
- WIDTH=8, SETTLE_CYCLES=16, strap_in=0xA5, release rst -> busy=1, cfg_valid=0 through edge 17; cfg_valid=1, cfg_out=0xA5, cfg_src=0 after edge 18.
- strap_in toggles 0xA5->0x5A between CAP_A and CAP_B -> return to SETTLE, busy stays 1, cfg_out=0x5A valid 18 edges after CAP_B.
- READY, ovr_wr_en with 0x3C -> cfg_out=0x3C, cfg_src=1 next edge; later strap change -> mismatch stays 0.
- READY from straps 0xA5, force strap_in=0xA4 -> mismatch=1 one edge later; cap_req -> cfg_valid=0, re-capture 0xA4, mismatch=0.
- Same cycle cap_req and ovr_wr_en=0xFF -> re-capture wins, cfg_out never 0xFF; then ovr_lock=1, subsequent ovr_wr_en/cap_req -> no change, locked=1.
- Assert rst during CAP_B and during locked READY -> all outputs return to reset values asynchronously, locked=0.
